// File: rtl/flp32_addsub_out_buf.sv
// flp32_addsub_out_buf: pair FIFO that serialises {add, sub} results into one word per cycle.
// Optional FLP_OUT_CLASS_EN adds out_class, a zero/inf/nan classification of out_data.
module flp32_addsub_out_buf #(
    parameter int DEPTH = 4,
    parameter int CW    = 3
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          flush,
    input  logic          in_valid,
    output logic          in_ready,
    input  logic [31:0]   add_in,
    input  logic [31:0]   sub_in,
    output logic          out_valid,
    input  logic          out_ready,
    output logic [31:0]   out_data,
    output logic          out_is_sub,
    output logic [CW-1:0] count
`ifdef FLP_OUT_CLASS_EN
    ,
    output logic [1:0]    out_class
`endif
);
    localparam int AW = $clog2(DEPTH);

    typedef enum logic {EMIT_ADD, EMIT_SUB} phase_t;

    logic [63:0]   mem [DEPTH];
    logic [AW-1:0] wr_ptr, rd_ptr;
    phase_t        phase, phase_nx;
    logic          push, pop, take;
    logic [63:0]   head;

    assign in_ready   = count != CW'(DEPTH);
    assign out_valid  = count != '0;
    assign push       = in_valid && in_ready;
    assign take       = out_valid && out_ready;
    assign pop        = take && phase == EMIT_SUB;
    assign head       = mem[rd_ptr];
    assign out_data   = !out_valid ? 32'h0 : phase == EMIT_SUB ? head[31:0] : head[63:32];
    assign out_is_sub = phase == EMIT_SUB;

    always_comb begin
        phase_nx = phase;
        if (take)
            phase_nx = phase == EMIT_ADD ? EMIT_SUB : EMIT_ADD;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
            phase  <= EMIT_ADD;
        end else if (flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
            phase  <= EMIT_ADD;
        end else begin
            wr_ptr <= wr_ptr + AW'(push);
            rd_ptr <= rd_ptr + AW'(pop);
            count  <= count + CW'(push) - CW'(pop);
            phase  <= phase_nx;
        end
    end

    // storage is deliberately not reset; count gates every read
    always_ff @(posedge clk) begin
        if (push && !flush)
            mem[wr_ptr] <= {add_in, sub_in};
    end

`ifdef FLP_OUT_CLASS_EN
    logic [7:0] exp_f;
    logic       frac_nz;
    assign exp_f     = out_data[30:23];
    assign frac_nz   = |out_data[22:0];
    assign out_class = !out_valid ? 2'b00 :
                       exp_f == 8'h00 && !frac_nz ? 2'b01 :
                       exp_f == 8'hFF ? (frac_nz ? 2'b11 : 2'b10) : 2'b00;
`endif
endmodule

// File: tb/tb_flp32_addsub_out_buf.sv
// tb_flp32_addsub_out_buf: directed self-checking bench for the fp32 add/sub output buffer.
// Exercises out_class too when FLP_OUT_CLASS_EN is defined.
module tb_flp32_addsub_out_buf;
    logic        clk, rst_n, flush, in_valid, in_ready, out_valid, out_ready, out_is_sub;
    logic [31:0] add_in, sub_in, out_data;
    logic [2:0]  count;
    int          passed = 0;
    int          total = 0;
    int          k, sent;
`ifdef FLP_OUT_CLASS_EN
    logic [1:0]  out_class;
`endif

    flp32_addsub_out_buf #(.DEPTH(4), .CW(3)) dut (
        .clk(clk), .rst_n(rst_n), .flush(flush),
        .in_valid(in_valid), .in_ready(in_ready),
        .add_in(add_in), .sub_in(sub_in),
        .out_valid(out_valid), .out_ready(out_ready),
        .out_data(out_data), .out_is_sub(out_is_sub), .count(count)
`ifdef FLP_OUT_CLASS_EN
        , .out_class(out_class)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) passed++;
        else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    endtask

    task automatic put(input logic [31:0] a, input logic [31:0] s);
        in_valid = 1'b1;
        add_in = a;
        sub_in = s;
        tick();
        in_valid = 1'b0;
    endtask

    initial begin
        rst_n = 1'b0; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
        add_in = '0; sub_in = '0;
        #12;
        chk("rst_in_ready", 32'(in_ready), 32'd1);
        chk("rst_out_valid", 32'(out_valid), 32'd0);
        chk("rst_count", 32'(count), 32'd0);
        chk("rst_out_data", out_data, 32'h0);
        chk("rst_is_sub", 32'(out_is_sub), 32'd0);
        rst_n = 1'b1;
        tick();

        // single pair, consumer always ready
        out_ready = 1'b1;
        put(32'h40400000, 32'h3F800000);
        chk("one_add", out_data, 32'h40400000);
        chk("one_add_tag", 32'(out_is_sub), 32'd0);
        chk("one_count", 32'(count), 32'd1);
        tick();
        chk("one_sub", out_data, 32'h3F800000);
        chk("one_sub_tag", 32'(out_is_sub), 32'd1);
        tick();
        chk("one_empty_valid", 32'(out_valid), 32'd0);
        chk("one_empty_count", 32'(count), 32'd0);

        // fill with consumer stalled
        out_ready = 1'b0;
        for (int i = 0; i < 4; i++) put(32'h40400000 + i, 32'h3F800000 + i);
        chk("full_count", 32'(count), 32'd4);
        chk("full_in_ready", 32'(in_ready), 32'd0);
        put(32'hDEADBEEF, 32'hDEADBEEF);
        chk("full_refuse_count", 32'(count), 32'd4);
        chk("full_hold_data", out_data, 32'h40400000);
        chk("full_hold_tag", 32'(out_is_sub), 32'd0);

        // full with simultaneous pop: push refused
        out_ready = 1'b1;
        tick();
        chk("full_sub_tag", 32'(out_is_sub), 32'd1);
        chk("full_sub_data", out_data, 32'h3F800000);
        put(32'h11111111, 32'h22222222);
        chk("fullpop_count", 32'(count), 32'd3);
        chk("fullpop_in_ready", 32'(in_ready), 32'd1);
        for (int j = 1; j < 4; j++) begin
            chk("drain_add", out_data, 32'h40400000 + j);
            chk("drain_add_tag", 32'(out_is_sub), 32'd0);
            tick();
            chk("drain_sub", out_data, 32'h3F800000 + j);
            chk("drain_sub_tag", 32'(out_is_sub), 32'd1);
            tick();
        end
        chk("drain_empty", 32'(out_valid), 32'd0);
        chk("drain_count", 32'(count), 32'd0);

        // 10 pairs through the wrapping pointers under random stalls
        k = 0;
        sent = 0;
        for (int cyc = 0; cyc < 400 && k < 20; cyc++) begin
            in_valid = sent < 10;
            add_in = 32'h3F800000 + sent;
            sub_in = 32'hBF800000 + sent;
            out_ready = 1'($urandom_range(0, 1));
            if (in_valid && in_ready) sent++;
            if (out_valid && out_ready) begin
                chk("wrap_data", out_data, k[0] ? 32'hBF800000 + (k >> 1) : 32'h3F800000 + (k >> 1));
                chk("wrap_tag", 32'(out_is_sub), 32'(k[0]));
                k++;
            end
            tick();
        end
        in_valid = 1'b0;
        out_ready = 1'b0;
        chk("wrap_words", k, 32'd20);
        chk("wrap_empty", 32'(out_valid), 32'd0);

        // flush in EMIT_SUB with a concurrent push
        put(32'hA0000001, 32'hB0000001);
        put(32'hA0000002, 32'hB0000002);
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
        chk("pre_flush_tag", 32'(out_is_sub), 32'd1);
        chk("pre_flush_count", 32'(count), 32'd2);
        flush = 1'b1;
        in_valid = 1'b1;
        add_in = 32'hCCCCCCCC;
        sub_in = 32'hDDDDDDDD;
        #1;
        chk("flush_in_ready", 32'(in_ready), 32'd1);
        tick();
        flush = 1'b0;
        in_valid = 1'b0;
        chk("flush_count", 32'(count), 32'd0);
        chk("flush_valid", 32'(out_valid), 32'd0);
        chk("flush_tag", 32'(out_is_sub), 32'd0);
        put(32'h12345678, 32'h9ABCDEF0);
        chk("post_flush_add", out_data, 32'h12345678);
        chk("post_flush_tag", 32'(out_is_sub), 32'd0);

        // asynchronous reset while in EMIT_SUB
        out_ready = 1'b1;
        tick();
        chk("pre_rst_tag", 32'(out_is_sub), 32'd1);
        out_ready = 1'b0;
        #2 rst_n = 1'b0;
        #1;
        chk("arst_count", 32'(count), 32'd0);
        chk("arst_valid", 32'(out_valid), 32'd0);
        chk("arst_tag", 32'(out_is_sub), 32'd0);
        rst_n = 1'b1;
        put(32'h77777777, 32'h88888888);
        chk("post_rst_add", out_data, 32'h77777777);
        chk("post_rst_tag", 32'(out_is_sub), 32'd0);
        out_ready = 1'b1;
        tick();
        chk("post_rst_sub", out_data, 32'h88888888);
        tick();
        out_ready = 1'b0;
        chk("post_rst_empty", 32'(out_valid), 32'd0);

`ifdef FLP_OUT_CLASS_EN
        chk("class_idle", 32'(out_class), 32'd0);
        put(32'h00000000, 32'h7F800000);
        put(32'h7FC00000, 32'hC0000000);
        chk("class_zero", 32'(out_class), 32'd1);
        out_ready = 1'b1;
        tick();
        chk("class_inf", 32'(out_class), 32'd2);
        tick();
        chk("class_nan", 32'(out_class), 32'd3);
        tick();
        chk("class_norm", 32'(out_class), 32'd0);
        tick();
        out_ready = 1'b0;
        chk("class_empty", 32'(out_class), 32'd0);
`endif

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule
